// File: rtl/ev2_arb_pkg.sv
// Shared definitions for the ev2 frame arbiter: FSM state encodings and the
// ev2 sink word width.
package ev2_arb_pkg;

    localparam int EV2_WORD_W = 16;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_ARB      = 3'd1,
        ARB_STREAM   = 3'd2,
        ARB_RST_REQ  = 3'd3,
        ARB_RST_WAIT = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: scans req_i starting at ptr_i+1 and
// wrapping, so the last winner (ptr_i) is considered last.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] k;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        pos      = '0;
        k        = '0;
        for (int i = 1; i <= N; i++) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N)) begin
                pos = pos - (IDX_W+1)'(N);
            end
            k = pos[IDX_W-1:0];
            if (!valid_o && req_i[k]) begin
                valid_o     = 1'b1;
                idx_o       = k;
                onehot_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ev2_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one ev2 sink between NUM_SRC sources,
// with sink reset handshake on flush. Define EV2_FRAME_ARB_STATS_EN for counters.
module ev2_frame_arbiter
    import ev2_arb_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FIFO_DEPTH = 32768,
    parameter int LEN_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_SRC-1:0]            req_i,
    input  logic [NUM_SRC*LEN_W-1:0]      len_i,
    input  logic [NUM_SRC*EV2_WORD_W-1:0] dat_i,
    input  logic [NUM_SRC-1:0]            wr_i,
    output logic [NUM_SRC-1:0]            gnt_o,
    output logic                          rdy_o,
    output logic [NUM_SRC-1:0]            done_o,
    output logic [NUM_SRC-1:0]            err_o,
    input  logic                          flush_i,
    output logic [EV2_WORD_W-1:0]         dat_o,
    output logic                          wr_o,
    input  logic [15:0]                   count_i,
    input  logic                          full_i,
    output logic                          rst_o,
    input  logic                          rst_ack_i
`ifdef EV2_FRAME_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]         frame_cnt_o,
    output logic [15:0]                   abort_cnt_o
`endif
);

    localparam int             IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(FIFO_DEPTH);

    // Occupancy above the nominal depth means no room at all, not a wrapped value.
    function automatic logic [LEN_W:0] free_words(input logic [15:0] cnt);
        logic signed [32:0] diff;
        diff = $signed(33'(FIFO_DEPTH)) - $signed({17'd0, cnt});
        if (diff[32]) begin
            return '0;
        end
        return diff[LEN_W:0];
    endfunction

    arb_state_e              state_q, state_d;
    logic [NUM_SRC-1:0]      gnt_q, gnt_d, done_q, done_d, err_q, err_d, mask_q, mask_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [EV2_WORD_W-1:0]   dat_q, dat_d;

    logic [NUM_SRC-1:0]      cand_oh;
    logic [IDX_W-1:0]        cand_idx;
    logic                    cand_vld;
    logic [LEN_W-1:0]        cand_len;
    logic [EV2_WORD_W-1:0]   sel_dat;
    logic                    sel_wr;
    logic                    busy, accept, len_ok, len_fits;

    // Sources already rejected in this arbitration round are masked out.
    rr_pick #(.N(NUM_SRC), .IDX_W(IDX_W)) u_pick (
        .req_i    (req_i & ~mask_q),
        .ptr_i    (ptr_q),
        .onehot_o (cand_oh),
        .idx_o    (cand_idx),
        .valid_o  (cand_vld)
    );

    always_comb begin
        sel_dat  = '0;
        sel_wr   = 1'b0;
        cand_len = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ptr_q == IDX_W'(i)) begin
                sel_dat = dat_i[i*EV2_WORD_W +: EV2_WORD_W];
                sel_wr  = wr_i[i];
            end
            if (cand_idx == IDX_W'(i)) begin
                cand_len = len_i[i*LEN_W +: LEN_W];
            end
        end
    end

    assign busy     = (state_q == ARB_STREAM);
    assign rdy_o    = busy & ~full_i;
    assign accept   = rdy_o & sel_wr;
    assign len_ok   = (cand_len != '0) && ({1'b0, cand_len} <= DEPTH_L);
    assign len_fits = ({1'b0, cand_len} <= free_words(count_i));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        done_d  = '0;
        err_d   = '0;
        wr_d    = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            ARB_IDLE: begin
                mask_d = '0;
                if (|req_i) state_d = ARB_ARB;
            end
            ARB_ARB: begin
                if (!cand_vld) begin
                    state_d = ARB_IDLE;
                    mask_d  = '0;
                end else if (!len_ok) begin
                    err_d  = cand_oh;
                    mask_d = mask_q | cand_oh;
                end else if (len_fits) begin
                    gnt_d   = cand_oh;
                    cnt_d   = cand_len;
                    ptr_d   = cand_idx;
                    mask_d  = '0;
                    state_d = ARB_STREAM;
                end
            end
            ARB_STREAM: begin
                dat_d = sel_dat;
                wr_d  = accept;
                if (accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        done_d  = gnt_q;
                        gnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_RST_REQ:  if (rst_ack_i)  state_d = ARB_RST_WAIT;
            ARB_RST_WAIT: if (!rst_ack_i) state_d = ARB_IDLE;
            default:      state_d = ARB_IDLE;
        endcase
        if (flush_i && (state_q inside {ARB_IDLE, ARB_ARB, ARB_STREAM})) begin
            state_d = ARB_RST_REQ;
            gnt_d   = '0;
            wr_d    = 1'b0;
            done_d  = '0;
            err_d   = '0;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            done_q  <= '0;
            err_q   <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign wr_o   = wr_q;
    assign dat_o  = dat_q;
    assign rst_o  = (state_q == ARB_RST_REQ);

`ifdef EV2_FRAME_ARB_STATS_EN
    logic [31:0] frame_cnt_q [NUM_SRC];
    logic [15:0] abort_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_SRC; i++) frame_cnt_q[i] <= '0;
            abort_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (done_d[i]) frame_cnt_q[i] <= frame_cnt_q[i] + 32'd1;
            end
            if (flush_i && busy && (abort_cnt_q != 16'hFFFF)) begin
                abort_cnt_q <= abort_cnt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_frame_cnt
        assign frame_cnt_o[g*32 +: 32] = frame_cnt_q[g];
    end
    assign abort_cnt_o = abort_cnt_q;
`endif

endmodule

// File: tb/tb_ev2_frame_arbiter.sv
// Scoreboard bench for ev2_frame_arbiter: per-source frame drivers push expected
// words on accept; a negedge monitor pops and compares against the sink side.
module tb_ev2_frame_arbiter;

    localparam int NUM_SRC    = 2;
    localparam int FIFO_DEPTH = 32768;
    localparam int LEN_W      = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_SRC-1:0]       req_i;
    logic [NUM_SRC*LEN_W-1:0] len_i;
    logic [NUM_SRC*16-1:0]    dat_i;
    logic [NUM_SRC-1:0]       wr_i;
    logic [NUM_SRC-1:0]       gnt_o, done_o, err_o;
    logic                     rdy_o, flush_i, wr_o, full_i, rst_o, rst_ack_i;
    logic [15:0]              dat_o, count_i;
`ifdef EV2_FRAME_ARB_STATS_EN
    logic [NUM_SRC*32-1:0]    frame_cnt_o;
    logic [15:0]              abort_cnt_o;
`endif

    always #5 clk = ~clk;

    ev2_frame_arbiter #(.NUM_SRC(NUM_SRC), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .len_i(len_i), .dat_i(dat_i),
        .wr_i(wr_i), .gnt_o(gnt_o), .rdy_o(rdy_o), .done_o(done_o), .err_o(err_o),
        .flush_i(flush_i), .dat_o(dat_o), .wr_o(wr_o), .count_i(count_i),
        .full_i(full_i), .rst_o(rst_o), .rst_ack_i(rst_ack_i)
`ifdef EV2_FRAME_ARB_STATS_EN
        , .frame_cnt_o(frame_cnt_o), .abort_cnt_o(abort_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_q[$];
    int          gnt_hist[$];
    logic [15:0] exp_w;
    int  frames_left[NUM_SRC], flen[NUM_SRC], sent[NUM_SRC], fid[NUM_SRC];
    int  frames_done[NUM_SRC], done_cnt[NUM_SRC], err_cnt[NUM_SRC];
    bit  active[NUM_SRC], in_frame[NUM_SRC], acc[NUM_SRC];
    bit  gap_en = 1'b0;
    int  wr_cnt = 0;
    logic [NUM_SRC-1:0] gnt_prev = '0;

    function automatic logic [15:0] mkword(input int s, input int f, input int k);
        return 16'(s * 4096 + (f % 16) * 256 + (k % 256));
    endfunction

    // Source models: hold req until grant, then stream flen words, holding each word until accepted.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            req_i = '0; wr_i = '0; len_i = '0; dat_i = '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (acc[s]) begin
                    exp_q.push_back(mkword(s, fid[s], sent[s]));
                    sent[s]++;
                    if (sent[s] == flen[s]) begin
                        in_frame[s] = 1'b0; active[s] = 1'b0;
                        frames_left[s]--; frames_done[s]++; fid[s]++;
                    end
                end
                if (active[s] && !in_frame[s] && gnt_o[s]) begin
                    in_frame[s] = 1'b1; sent[s] = 0;
                end
                if (active[s] && !in_frame[s] && err_o[s]) begin
                    active[s] = 1'b0; frames_left[s]--;
                end
                if (!active[s] && frames_left[s] > 0) active[s] = 1'b1;
                req_i[s] = active[s] && !in_frame[s];
                len_i[s*LEN_W +: LEN_W] = LEN_W'(flen[s]);
                wr_i[s] = in_frame[s] && (!gap_en || $urandom_range(0, 3) != 0);
                dat_i[s*16 +: 16] = mkword(s, fid[s], sent[s]);
            end
        end
    end

    always @(negedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            acc[s] = rst_n && gnt_o[s] && rdy_o && wr_i[s] && !flush_i;
        end
        if (rst_n) begin
            if (wr_o) begin
                wr_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_extra: wr_o with dat_o=%h, no word expected", dat_o);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (dat_o !== exp_w) begin
                        n_bad++;
                        $display("FAIL sb_data: dat_o=%h expected %h", dat_o, exp_w);
                    end
                end
            end
            for (int s = 0; s < NUM_SRC; s++) begin
                if (done_o[s]) begin
                    done_cnt[s]++;
                    n_cmp++;
                    if (wr_o !== 1'b1 || gnt_o[s] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL done_align src%0d: wr_o=%b gnt_o=%b expected wr_o=1 gnt low", s, wr_o, gnt_o);
                    end
                end
                if (err_o[s]) err_cnt[s]++;
            end
            if (gnt_o != '0 && gnt_prev == '0) begin
                n_cmp++;
                if ($countones(gnt_o) != 1) begin
                    n_bad++;
                    $display("FAIL gnt_onehot: gnt_o=%b expected one-hot", gnt_o);
                end
                for (int s = 0; s < NUM_SRC; s++) if (gnt_o[s]) gnt_hist.push_back(s);
            end
            gnt_prev = gnt_o;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_all(input int limit, output bit ok);
        bit idle;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            idle = 1'b1;
            for (int s = 0; s < NUM_SRC; s++) if (frames_left[s] != 0 || active[s]) idle = 1'b0;
            if (idle) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; full_i = 1'b0; count_i = '0; rst_ack_i = 1'b0;
        repeat (3) cyc();
        n_cmp += 7;
        if (gnt_o !== '0)  begin n_bad++; $display("FAIL rst_gnt: %b required 0", gnt_o); end
        if (rdy_o !== 1'b0) begin n_bad++; $display("FAIL rst_rdy: %b required 0", rdy_o); end
        if (done_o !== '0) begin n_bad++; $display("FAIL rst_done: %b required 0", done_o); end
        if (err_o !== '0)  begin n_bad++; $display("FAIL rst_err: %b required 0", err_o); end
        if (wr_o !== 1'b0) begin n_bad++; $display("FAIL rst_wr: %b required 0", wr_o); end
        if (dat_o !== '0)  begin n_bad++; $display("FAIL rst_dat: %h required 0", dat_o); end
        if (rst_o !== 1'b0) begin n_bad++; $display("FAIL rst_rsto: %b required 0", rst_o); end
        rst_n = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_single();
        int n, w0, d0;
        bit ok;
        w0 = wr_cnt; d0 = done_cnt[0];
        flen[0] = 4; frames_left[0] = 1;
        n = 0;
        while (!req_i[0] && n < 5) begin cyc(); n++; end
        n = 0;
        while (!gnt_o[0] && n < 10) begin cyc(); n++; end
        n_cmp++;
        if (n != 2) begin n_bad++; $display("FAIL single_gnt_latency: %0d cycles required 2", n); end
        wait_all(100, ok);
        n_cmp += 5;
        if (!ok) begin n_bad++; $display("FAIL single_timeout: frame incomplete, required done"); end
        if (wr_cnt - w0 != 4) begin n_bad++; $display("FAIL single_words: %0d required 4", wr_cnt - w0); end
        if (done_cnt[0] - d0 != 1) begin n_bad++; $display("FAIL single_done: %0d required 1", done_cnt[0] - d0); end
        if (gnt_o !== '0) begin n_bad++; $display("FAIL single_gnt_drop: %b required 0", gnt_o); end
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL single_drain: %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int order[4] = '{1, 0, 1, 0};
        bit ok;
        gnt_hist.delete();
        gap_en = 1'b1;
        flen[0] = 3; flen[1] = 3; frames_left[0] = 2; frames_left[1] = 2;
        wait_all(300, ok);
        gap_en = 1'b0;
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL b2b_timeout: frames incomplete, required done"); end
        if (gnt_hist.size() != 4) begin
            n_bad++; $display("FAIL b2b_grants: %0d grants required 4", gnt_hist.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (gnt_hist[i] != order[i]) begin
                    n_bad++; $display("FAIL b2b_order[%0d]: src%0d required src%0d", i, gnt_hist[i], order[i]);
                end
            end
        end
    endtask

    task automatic test_space();
        int e0;
        bit ok;
        e0 = err_cnt[0];
        count_i = 16'd40000;
        flen[0] = 4; frames_left[0] = 1;
        repeat (6) cyc();
        n_cmp++;
        if (gnt_o !== '0) begin n_bad++; $display("FAIL space_sat: gnt_o=%b required 0", gnt_o); end
        count_i = 16'(FIFO_DEPTH - 3);
        repeat (4) cyc();
        n_cmp++;
        if (gnt_o !== '0) begin n_bad++; $display("FAIL space_short: gnt_o=%b required 0", gnt_o); end
        count_i = 16'(FIFO_DEPTH - 4);
        cyc();
        n_cmp++;
        if (gnt_o !== 2'b01) begin n_bad++; $display("FAIL space_fit: gnt_o=%b required 01", gnt_o); end
        count_i = '0;
        wait_all(100, ok);
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL space_timeout: frame incomplete, required done"); end
        if (err_cnt[0] != e0) begin n_bad++; $display("FAIL space_err: %0d err pulses required 0", err_cnt[0] - e0); end
    endtask

    task automatic test_full();
        int w0, d0, snap, n;
        bit ok;
        w0 = wr_cnt; d0 = done_cnt[0];
        flen[0] = 8; frames_left[0] = 1;
        n = 0;
        while (wr_cnt < w0 + 2 && n < 50) begin cyc(); n++; end
        full_i = 1'b1;
        cyc();
        snap = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            n_cmp += 2;
            if (rdy_o !== 1'b0) begin n_bad++; $display("FAIL full_rdy[%0d]: %b required 0", i, rdy_o); end
            if (wr_o !== 1'b0) begin n_bad++; $display("FAIL full_wr[%0d]: %b required 0", i, wr_o); end
            cyc();
        end
        n_cmp++;
        if (wr_cnt != snap) begin n_bad++; $display("FAIL full_hold: %0d words during full required 0", wr_cnt - snap); end
        full_i = 1'b0;
        wait_all(100, ok);
        n_cmp += 3;
        if (!ok) begin n_bad++; $display("FAIL full_timeout: frame incomplete, required done"); end
        if (wr_cnt - w0 != 8) begin n_bad++; $display("FAIL full_words: %0d required 8", wr_cnt - w0); end
        if (done_cnt[0] - d0 != 1) begin n_bad++; $display("FAIL full_done: %0d required 1", done_cnt[0] - d0); end
    endtask

    task automatic test_err();
        int e0, e1, d0, d1;
        bit ok;
        gnt_hist.delete();
        e0 = err_cnt[0]; e1 = err_cnt[1]; d0 = done_cnt[0]; d1 = done_cnt[1];
        flen[0] = 0; flen[1] = 4; frames_left[0] = 1; frames_left[1] = 1;
        wait_all(100, ok);
        n_cmp += 5;
        if (!ok) begin n_bad++; $display("FAIL err0_timeout: sources not settled, required settle"); end
        if (err_cnt[0] - e0 != 1) begin n_bad++; $display("FAIL err0_pulse: %0d required 1", err_cnt[0] - e0); end
        if (err_cnt[1] != e1) begin n_bad++; $display("FAIL err0_other: %0d err on src1 required 0", err_cnt[1] - e1); end
        if (done_cnt[1] - d1 != 1) begin n_bad++; $display("FAIL err0_served: %0d src1 frames required 1", done_cnt[1] - d1); end
        if (done_cnt[0] != d0) begin n_bad++; $display("FAIL err0_nodone: %0d src0 frames required 0", done_cnt[0] - d0); end
        flen[0] = FIFO_DEPTH + 1; frames_left[0] = 1;
        wait_all(100, ok);
        n_cmp += 3;
        if (!ok) begin n_bad++; $display("FAIL errbig_timeout: source not settled, required settle"); end
        if (err_cnt[0] - e0 != 2) begin n_bad++; $display("FAIL errbig_pulse: %0d total required 2", err_cnt[0] - e0); end
        if (gnt_hist.size() != 1) begin n_bad++; $display("FAIL err_grants: %0d grants required 1", gnt_hist.size()); end
    endtask

    task automatic test_flush();
        int w0, d0, n;
        bit ok;
        w0 = wr_cnt; d0 = done_cnt[0];
        flen[0] = 8; frames_left[0] = 1;
        n = 0;
        while (wr_cnt < w0 + 2 && n < 50) begin cyc(); n++; end
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        frames_left[0] = 0; active[0] = 1'b0; in_frame[0] = 1'b0;
        n_cmp += 4;
        if (wr_o !== 1'b0) begin n_bad++; $display("FAIL flush_wr: %b required 0", wr_o); end
        if (gnt_o !== '0)  begin n_bad++; $display("FAIL flush_gnt: %b required 0", gnt_o); end
        if (rdy_o !== 1'b0) begin n_bad++; $display("FAIL flush_rdy: %b required 0", rdy_o); end
        if (rst_o !== 1'b1) begin n_bad++; $display("FAIL flush_rsto: %b required 1", rst_o); end
        repeat (3) cyc();
        n_cmp++;
        if (rst_o !== 1'b1) begin n_bad++; $display("FAIL flush_rst_hold: %b required 1", rst_o); end
        rst_ack_i = 1'b1;
        cyc();
        n_cmp++;
        if (rst_o !== 1'b0) begin n_bad++; $display("FAIL flush_ack: rst_o=%b required 0", rst_o); end
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        n_cmp++;
        if (rst_o !== 1'b0) begin n_bad++; $display("FAIL flush_absorb: rst_o=%b required 0", rst_o); end
        rst_ack_i = 1'b0;
        repeat (3) cyc();
        n_cmp += 3;
        if (done_cnt[0] != d0) begin n_bad++; $display("FAIL flush_nodone: %0d required 0", done_cnt[0] - d0); end
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL flush_drain: %0d left required 0", exp_q.size()); end
        if (rst_o !== 1'b0) begin n_bad++; $display("FAIL flush_idle_rsto: %b required 0", rst_o); end
`ifdef EV2_FRAME_ARB_STATS_EN
        n_cmp += 3;
        if (abort_cnt_o !== 16'd1) begin n_bad++; $display("FAIL stats_abort: %0d required 1", abort_cnt_o); end
        if (frame_cnt_o[31:0] !== 32'(frames_done[0])) begin
            n_bad++; $display("FAIL stats_frames0: %0d required %0d", frame_cnt_o[31:0], frames_done[0]);
        end
        if (frame_cnt_o[63:32] !== 32'(frames_done[1])) begin
            n_bad++; $display("FAIL stats_frames1: %0d required %0d", frame_cnt_o[63:32], frames_done[1]);
        end
`endif
        d0 = done_cnt[1];
        flen[1] = 2; frames_left[1] = 1;
        wait_all(100, ok);
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL flush_recover_timeout: frame incomplete, required done"); end
        if (done_cnt[1] - d0 != 1) begin n_bad++; $display("FAIL flush_recover: %0d frames required 1", done_cnt[1] - d0); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_i = '0; wr_i = '0; len_i = '0; dat_i = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_space();
        test_full();
        test_err();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
